// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
// Holds the controller state enum, the latched bus command and the fetch command helper.
package rv_mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_IFU,
      REQ_LSU,
      WAIT_IFU,
      WAIT_LSU
   } rv_arb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } rv_bus_cmd_t;

   localparam logic [3:0] IFU_SEL = 4'hF;

   // Fetches are always full-word reads.
   function automatic rv_bus_cmd_t make_ifu_cmd(input logic [31:0] addr);
      rv_bus_cmd_t cmd;
      cmd.addr  = addr;
      cmd.we    = 1'b0;
      cmd.sel   = IFU_SEL;
      cmd.wdata = 32'h0;
      return cmd;
   endfunction

endpackage

// File: rtl/rv_mem_arb_if.sv
// Fetch, load/store and memory-bus signal bundle of the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core and bus.
interface rv_mem_arb_if;

   logic        i_ifu_req;
   logic [31:0] i_ifu_addr;
   logic        i_ifu_flush;
   logic        o_ifu_ack;
   logic        o_ifu_rvalid;
   logic [31:0] o_ifu_rdata;

   logic        i_lsu_req;
   logic [31:0] i_lsu_addr;
   logic        i_lsu_we;
   logic [3:0]  i_lsu_sel;
   logic [31:0] i_lsu_wdata;
   logic        o_lsu_ack;
   logic        o_lsu_rvalid;
   logic [31:0] o_lsu_rdata;

   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_sel;
   logic        i_bus_ack;
   logic        i_bus_rvalid;
   logic [31:0] i_bus_rdata;

   logic        o_busy;

   modport slave (
      input  i_ifu_req, i_ifu_addr, i_ifu_flush,
      output o_ifu_ack, o_ifu_rvalid, o_ifu_rdata,
      input  i_lsu_req, i_lsu_addr, i_lsu_we, i_lsu_sel, i_lsu_wdata,
      output o_lsu_ack, o_lsu_rvalid, o_lsu_rdata,
      output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_sel,
      input  i_bus_ack, i_bus_rvalid, i_bus_rdata,
      output o_busy
   );

   modport master (
      output i_ifu_req, i_ifu_addr, i_ifu_flush,
      input  o_ifu_ack, o_ifu_rvalid, o_ifu_rdata,
      output i_lsu_req, i_lsu_addr, i_lsu_we, i_lsu_sel, i_lsu_wdata,
      input  o_lsu_ack, o_lsu_rvalid, o_lsu_rdata,
      input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_sel,
      output i_bus_ack, i_bus_rvalid, i_bus_rdata,
      input  o_busy
   );

endinterface

// File: rtl/rv_mem_arb.sv
// Two-master memory arbiter: LSU has priority, IFU is protected from starvation.
// One outstanding bus transaction; a pending request is issued back-to-back on completion.
module rv_mem_arb
   import rv_mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   rv_mem_arb_if.slave mem
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   rv_arb_state_t    state;
   logic [CNT_W-1:0] starve_cnt;
   logic             drop;
   logic             bus_req_q;
   rv_bus_cmd_t      cmd_q;

   logic ifu_ack, lsu_ack;
   logic ifu_resp, lsu_resp;
   logic done;
   logic ifu_pend, lsu_pend;
   logic starved, arb_en;
   logic grant_ifu, grant_lsu;
   logic ifu_rvalid;
   rv_bus_cmd_t lsu_cmd;

   // Handshake decode and arbitration. A requester's req is still high in the cycle
   // its own ack fires, so that request is masked out of the pending set.
   always_comb begin
      ifu_ack  = 1'b0;
      lsu_ack  = 1'b0;
      ifu_resp = 1'b0;
      lsu_resp = 1'b0;
      case (state)
         REQ_IFU: begin
            ifu_ack  = mem.i_bus_ack;
            ifu_resp = mem.i_bus_ack & mem.i_bus_rvalid;
         end
         REQ_LSU: begin
            lsu_ack  = mem.i_bus_ack;
            lsu_resp = mem.i_bus_ack & mem.i_bus_rvalid;
         end
         WAIT_IFU: ifu_resp = mem.i_bus_rvalid;
         WAIT_LSU: lsu_resp = mem.i_bus_rvalid;
         default: ;
      endcase
      if (i_reset) begin
         ifu_ack  = 1'b0;
         lsu_ack  = 1'b0;
         ifu_resp = 1'b0;
         lsu_resp = 1'b0;
      end
      done      = ifu_resp | lsu_resp;
      ifu_pend  = mem.i_ifu_req & ~ifu_ack;
      lsu_pend  = mem.i_lsu_req & ~lsu_ack;
      starved   = ifu_pend && (starve_cnt == STARVE_LIM);
      arb_en    = (state == IDLE) || done;
      grant_lsu = arb_en && lsu_pend && !starved;
      grant_ifu = arb_en && ifu_pend && !grant_lsu;
   end

   always_comb begin
      lsu_cmd.addr  = mem.i_lsu_addr;
      lsu_cmd.we    = mem.i_lsu_we;
      lsu_cmd.sel   = mem.i_lsu_sel;
      lsu_cmd.wdata = mem.i_lsu_wdata;
   end

   // Controller: state, starvation counter, flush-drop flag and registered bus command.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         drop       <= 1'b0;
         bus_req_q  <= 1'b0;
         cmd_q      <= '0;
      end else begin
         if (!ifu_pend || grant_ifu) begin
            starve_cnt <= '0;
         end else if (grant_lsu && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         if (done) begin
            drop <= 1'b0;
         end else if (mem.i_ifu_flush && ((state == REQ_IFU) || (state == WAIT_IFU))) begin
            drop <= 1'b1;
         end

         if (grant_lsu) begin
            state     <= REQ_LSU;
            bus_req_q <= 1'b1;
            cmd_q     <= lsu_cmd;
         end else if (grant_ifu) begin
            state     <= REQ_IFU;
            bus_req_q <= 1'b1;
            cmd_q     <= make_ifu_cmd(mem.i_ifu_addr);
         end else if (done) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
         end else if (ifu_ack) begin
            state     <= WAIT_IFU;
            bus_req_q <= 1'b0;
         end else if (lsu_ack) begin
            state     <= WAIT_LSU;
            bus_req_q <= 1'b0;
         end
      end
   end

   // A flush arriving together with the response also hides it.
   assign ifu_rvalid = ifu_resp & ~drop & ~mem.i_ifu_flush;

   assign mem.o_ifu_ack    = ifu_ack;
   assign mem.o_ifu_rvalid = ifu_rvalid;
   assign mem.o_ifu_rdata  = ifu_rvalid ? mem.i_bus_rdata : 32'h0;
   assign mem.o_lsu_ack    = lsu_ack;
   assign mem.o_lsu_rvalid = lsu_resp;
   assign mem.o_lsu_rdata  = lsu_resp ? mem.i_bus_rdata : 32'h0;

   assign mem.o_bus_req    = bus_req_q;
   assign mem.o_bus_we     = cmd_q.we;
   assign mem.o_bus_addr   = cmd_q.addr;
   assign mem.o_bus_wdata  = cmd_q.wdata;
   assign mem.o_bus_sel    = cmd_q.sel;
   assign mem.o_busy       = (state != IDLE);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: single fetch, contention, starvation limit,
// flush drop, same-cycle store completion and reset mid-transaction.
module tb_rv_mem_arb;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rv_mem_arb_if mem_if ();

   rv_mem_arb #(.STARVE_MAX(4)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .mem    (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ack, input logic rvalid, input logic [31:0] rdata);
      mem_if.i_bus_ack    = ack;
      mem_if.i_bus_rvalid = rvalid;
      mem_if.i_bus_rdata  = rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst                = 1'b1;
      mem_if.i_ifu_req   = 1'b0;
      mem_if.i_ifu_addr  = 32'h0;
      mem_if.i_ifu_flush = 1'b0;
      mem_if.i_lsu_req   = 1'b0;
      mem_if.i_lsu_addr  = 32'h0;
      mem_if.i_lsu_we    = 1'b0;
      mem_if.i_lsu_sel   = 4'h0;
      mem_if.i_lsu_wdata = 32'h0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      tick();

      @(negedge clk);
      checkOutput("rst_busy", 32'(mem_if.o_busy), 0);
      checkOutput("rst_bus_req", 32'(mem_if.o_bus_req), 0);
      checkOutput("rst_bus_addr", mem_if.o_bus_addr, 32'h0);
      rst = 1'b0;
      tick();

      // Single fetch: request cycle 0, ack cycle 2, data cycle 4.
      mem_if.i_ifu_req  = 1'b1;
      mem_if.i_ifu_addr = 32'h100;
      @(negedge clk);
      checkOutput("a_req_latency", 32'(mem_if.o_bus_req), 0);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h55);
      @(negedge clk);
      checkOutput("a_bus_req", 32'(mem_if.o_bus_req), 1);
      checkOutput("a_bus_addr", mem_if.o_bus_addr, 32'h100);
      checkOutput("a_bus_sel", 32'(mem_if.o_bus_sel), 32'hF);
      checkOutput("a_bus_we", 32'(mem_if.o_bus_we), 0);
      checkOutput("a_stale_rvalid", 32'(mem_if.o_ifu_rvalid), 0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("a_ifu_ack", 32'(mem_if.o_ifu_ack), 1);
      checkOutput("a_ack_no_rvalid", 32'(mem_if.o_ifu_rvalid), 0);
      tick();
      mem_if.i_ifu_req = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("a_wait_bus_req", 32'(mem_if.o_bus_req), 0);
      checkOutput("a_wait_busy", 32'(mem_if.o_busy), 1);
      tick();
      applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("a_ifu_rvalid", 32'(mem_if.o_ifu_rvalid), 1);
      checkOutput("a_ifu_rdata", mem_if.o_ifu_rdata, 32'hDEADBEEF);
      checkOutput("a_lsu_rdata", mem_if.o_lsu_rdata, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("a_idle_busy", 32'(mem_if.o_busy), 0);
      checkOutput("a_idle_rdata", mem_if.o_ifu_rdata, 32'h0);
      tick();

      // Simultaneous requests: LSU first, IFU issued on the LSU response cycle.
      mem_if.i_ifu_req  = 1'b1;
      mem_if.i_ifu_addr = 32'h200;
      mem_if.i_lsu_req  = 1'b1;
      mem_if.i_lsu_addr = 32'h300;
      mem_if.i_lsu_sel  = 4'hF;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("b_bus_addr_lsu", mem_if.o_bus_addr, 32'h300);
      checkOutput("b_lsu_ack", 32'(mem_if.o_lsu_ack), 1);
      checkOutput("b_no_ifu_ack", 32'(mem_if.o_ifu_ack), 0);
      tick();
      mem_if.i_lsu_req = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'hCAFE0001);
      @(negedge clk);
      checkOutput("b_lsu_rvalid", 32'(mem_if.o_lsu_rvalid), 1);
      checkOutput("b_lsu_rdata", mem_if.o_lsu_rdata, 32'hCAFE0001);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h11);
      @(negedge clk);
      checkOutput("b_b2b_bus_req", 32'(mem_if.o_bus_req), 1);
      checkOutput("b_b2b_addr", mem_if.o_bus_addr, 32'h200);
      checkOutput("b_ifu_ack", 32'(mem_if.o_ifu_ack), 1);
      checkOutput("b_ifu_rvalid", 32'(mem_if.o_ifu_rvalid), 1);
      tick();
      mem_if.i_ifu_req = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("b_idle_busy", 32'(mem_if.o_busy), 0);
      tick();

      // Starvation: IFU held, LSU re-requesting -> four LSU grants then the IFU.
      mem_if.i_ifu_req  = 1'b1;
      mem_if.i_ifu_addr = 32'h400;
      mem_if.i_lsu_req  = 1'b1;
      mem_if.i_lsu_addr = 32'h404;
      tick();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput($sformatf("c_lsu_ack_%0d", i), 32'(mem_if.o_lsu_ack), 32'(i < 4));
         checkOutput($sformatf("c_ifu_ack_%0d", i), 32'(mem_if.o_ifu_ack), 32'(i == 4));
         checkOutput($sformatf("c_addr_%0d", i), mem_if.o_bus_addr, (i < 4) ? 32'h404 : 32'h400);
         tick();
         if (i == 4) begin
            mem_if.i_ifu_req = 1'b0;
            mem_if.i_lsu_req = 1'b0;
         end
         applyStimulus(1'b0, 1'b1, 32'h1000 + 32'(i));
         @(negedge clk);
         checkOutput($sformatf("c_lsu_rvalid_%0d", i), 32'(mem_if.o_lsu_rvalid), 32'(i < 4));
         checkOutput($sformatf("c_ifu_rvalid_%0d", i), 32'(mem_if.o_ifu_rvalid), 32'(i == 4));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("c_idle_busy", 32'(mem_if.o_busy), 0);
      tick();

      // Flush while waiting for fetch data: response dropped, next fetch normal.
      mem_if.i_ifu_req  = 1'b1;
      mem_if.i_ifu_addr = 32'h500;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("d_ifu_ack", 32'(mem_if.o_ifu_ack), 1);
      tick();
      mem_if.i_ifu_req   = 1'b0;
      mem_if.i_ifu_flush = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      mem_if.i_ifu_flush = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'h77);
      @(negedge clk);
      checkOutput("d_dropped_rvalid", 32'(mem_if.o_ifu_rvalid), 0);
      checkOutput("d_dropped_rdata", mem_if.o_ifu_rdata, 32'h0);
      checkOutput("d_drop_busy", 32'(mem_if.o_busy), 1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      mem_if.i_ifu_req  = 1'b1;
      mem_if.i_ifu_addr = 32'h504;
      @(negedge clk);
      checkOutput("d_after_busy", 32'(mem_if.o_busy), 0);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h88);
      @(negedge clk);
      checkOutput("d_next_addr", mem_if.o_bus_addr, 32'h504);
      checkOutput("d_next_rvalid", 32'(mem_if.o_ifu_rvalid), 1);
      checkOutput("d_next_rdata", mem_if.o_ifu_rdata, 32'h88);
      tick();
      mem_if.i_ifu_req = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();

      // Store with ack and completion in the same cycle.
      mem_if.i_lsu_req   = 1'b1;
      mem_if.i_lsu_addr  = 32'h600;
      mem_if.i_lsu_we    = 1'b1;
      mem_if.i_lsu_sel   = 4'b0011;
      mem_if.i_lsu_wdata = 32'h1234;
      tick();
      applyStimulus(1'b1, 1'b1, 32'hAAAA);
      @(negedge clk);
      checkOutput("e_bus_we", 32'(mem_if.o_bus_we), 1);
      checkOutput("e_bus_sel", 32'(mem_if.o_bus_sel), 32'h3);
      checkOutput("e_bus_wdata", mem_if.o_bus_wdata, 32'h1234);
      checkOutput("e_lsu_ack", 32'(mem_if.o_lsu_ack), 1);
      checkOutput("e_lsu_rvalid", 32'(mem_if.o_lsu_rvalid), 1);
      tick();
      mem_if.i_lsu_req = 1'b0;
      mem_if.i_lsu_we  = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("e_idle_busy", 32'(mem_if.o_busy), 0);
      tick();

      // Reset while waiting for load data, then a stale response.
      mem_if.i_lsu_req  = 1'b1;
      mem_if.i_lsu_addr = 32'h700;
      mem_if.i_lsu_sel  = 4'hF;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0);
      tick();
      mem_if.i_lsu_req = 1'b0;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h99);
      @(negedge clk);
      checkOutput("f_rst_rvalid", 32'(mem_if.o_lsu_rvalid), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("f_stale_rvalid", 32'(mem_if.o_lsu_rvalid), 0);
      checkOutput("f_stale_rdata", mem_if.o_lsu_rdata, 32'h0);
      checkOutput("f_busy", 32'(mem_if.o_busy), 0);
      checkOutput("f_bus_req", 32'(mem_if.o_bus_req), 0);
      checkOutput("f_bus_addr", mem_if.o_bus_addr, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
